// File: rtl/datetime_pkg.sv
// Shared field encoding, range limits and calendar helpers for the date/time setter.
package datetime_pkg;

  typedef enum logic [2:0] {
    F_NORMAL = 3'd0,
    F_SS     = 3'd1,
    F_MI     = 3'd2,
    F_HH     = 3'd3,
    F_DD     = 3'd4,
    F_MO     = 3'd5,
    F_YL     = 3'd6,
    F_YH     = 3'd7
  } field_e;

  localparam logic [6:0] SEC_MAX   = 7'd59;
  localparam logic [6:0] MIN_MAX   = 7'd59;
  localparam logic [6:0] HOUR_MAX  = 7'd23;
  localparam logic [6:0] DAY_MIN   = 7'd1;
  localparam logic [6:0] MONTH_MIN = 7'd1;
  localparam logic [6:0] MONTH_MAX = 7'd12;
  localparam logic [6:0] YEAR_MAX  = 7'd99;

  localparam logic [5:0] RST_SEC   = 6'd0;
  localparam logic [5:0] RST_MIN   = 6'd0;
  localparam logic [4:0] RST_HOUR  = 5'd0;
  localparam logic [4:0] RST_DAY   = 5'd1;
  localparam logic [3:0] RST_MONTH = 4'd1;

  // Century years are leap only when year_hi is a multiple of four.
  function automatic logic is_leap(input logic [6:0] year_hi, input logic [6:0] year_lo);
    if (year_lo != 7'd0) is_leap = (year_lo[1:0] == 2'd0);
    else                 is_leap = (year_hi[1:0] == 2'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [6:0] year_hi,
                                               input logic [6:0] year_lo);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:    days_in_month = is_leap(year_hi, year_lo) ? 5'd29 : 5'd28;
      default: days_in_month = 5'd31;
    endcase
  endfunction

  function automatic logic [6:0] step_wrap(input logic [6:0] val, input logic [6:0] lo,
                                           input logic [6:0] hi, input logic up);
    if (up) step_wrap = (val >= hi) ? lo : val + 7'd1;
    else    step_wrap = (val <= lo) ? hi : val - 7'd1;
  endfunction

endpackage

// File: rtl/datetime_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce and a one-cycle press pulse.
// With DTSET_AUTOREPEAT_EN defined, a held button also emits periodic repeat steps.
module btn_debounce
  import datetime_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef DTSET_AUTOREPEAT_EN
  , parameter bit REPEAT_EN     = 1'b0
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic step
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs only while the synced level disagrees with the accepted level.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + CW'(1);
    end
    press_d = level_q & ~level_d;
  end

`ifdef DTSET_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_phase_q, rpt_phase_d;
  logic          rpt_q, rpt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
      rpt_q       <= rpt_d;
    end
  end

  // Phase 0 waits out the initial delay, phase 1 paces the following repeats.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_phase_d = 1'b0;
    rpt_d       = 1'b0;
    if (REPEAT_EN && !level_q && !press_q) begin
      rpt_phase_d = rpt_phase_q;
      if (rpt_cnt_q == (rpt_phase_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
        rpt_d       = 1'b1;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
      end
    end
  end

  assign step = press_q | rpt_q;
`else
  assign step = press_q;
`endif

endmodule

// File: rtl/datetime_set_ctrl.sv
// Calendar/time register owner: ticks in NORMAL, edits the selected field from buttons otherwise.
// Optional auto-repeat of up/down steps is enabled with DTSET_AUTOREPEAT_EN.
module datetime_set_ctrl
  import datetime_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_YEAR_HI   = 20,
  parameter int RESET_YEAR_LO   = 0
`ifdef DTSET_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mode_btn_n,
  input  logic       up_btn_n,
  input  logic       down_btn_n,
  output logic [2:0] field,
  output logic       editing,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year_lo,
  output logic [6:0] year_hi
);

  logic mode_p, up_p, dn_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef DTSET_AUTOREPEAT_EN
    , .REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_mode (.clk(clk), .rst(rst), .btn_n(mode_btn_n), .step(mode_p));

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef DTSET_AUTOREPEAT_EN
    , .REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_up (.clk(clk), .rst(rst), .btn_n(up_btn_n), .step(up_p));

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef DTSET_AUTOREPEAT_EN
    , .REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_dn (.clk(clk), .rst(rst), .btn_n(down_btn_n), .step(dn_p));

  field_e     field_q, field_d;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hour_q, hour_d, day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_lo_q, year_lo_d, year_hi_q, year_hi_d;
  logic [4:0] dim_cur, dim_new;
  logic       step_up, step_dn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field_q   <= F_NORMAL;
      sec_q     <= RST_SEC;
      min_q     <= RST_MIN;
      hour_q    <= RST_HOUR;
      day_q     <= RST_DAY;
      month_q   <= RST_MONTH;
      year_lo_q <= 7'(RESET_YEAR_LO);
      year_hi_q <= 7'(RESET_YEAR_HI);
    end else begin
      field_q   <= field_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      month_q   <= month_d;
      year_lo_q <= year_lo_d;
      year_hi_q <= year_hi_d;
    end
  end

  assign dim_cur = days_in_month(month_q, year_hi_q, year_lo_q);

  // Mode wins over up/down; simultaneous up+down cancels; ticks only count in NORMAL.
  always_comb begin
    field_d   = field_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    day_d     = day_q;
    month_d   = month_q;
    year_lo_d = year_lo_q;
    year_hi_d = year_hi_q;
    dim_new   = dim_cur;
    step_up   = up_p & ~dn_p;
    step_dn   = dn_p & ~up_p;

    if (mode_p) begin
      field_d = field_e'(field_q + 3'd1);
    end else if (field_q != F_NORMAL) begin
      if (step_up || step_dn) begin
        case (field_q)
          F_SS:    sec_d     = 6'(step_wrap(7'(sec_q), 7'd0, SEC_MAX, step_up));
          F_MI:    min_d     = 6'(step_wrap(7'(min_q), 7'd0, MIN_MAX, step_up));
          F_HH:    hour_d    = 5'(step_wrap(7'(hour_q), 7'd0, HOUR_MAX, step_up));
          F_DD:    day_d     = 5'(step_wrap(7'(day_q), DAY_MIN, 7'(dim_cur), step_up));
          F_MO:    month_d   = 4'(step_wrap(7'(month_q), MONTH_MIN, MONTH_MAX, step_up));
          F_YL:    year_lo_d = step_wrap(year_lo_q, 7'd0, YEAR_MAX, step_up);
          F_YH:    year_hi_d = step_wrap(year_hi_q, 7'd0, YEAR_MAX, step_up);
          default: ;
        endcase
        dim_new = days_in_month(month_d, year_hi_d, year_lo_d);
        if ((field_q inside {F_MO, F_YL, F_YH}) && (day_q > dim_new)) day_d = dim_new;
      end
    end else if (tick_1hz) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d = 5'd0;
            if (day_q == dim_cur) begin
              day_d = 5'd1;
              if (month_q == 4'd12) begin
                month_d = 4'd1;
                if (year_lo_q == 7'd99) begin
                  year_lo_d = 7'd0;
                  year_hi_d = (year_hi_q == 7'd99) ? 7'd0 : year_hi_q + 7'd1;
                end else begin
                  year_lo_d = year_lo_q + 7'd1;
                end
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              day_d = day_q + 5'd1;
            end
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  assign field   = field_q;
  assign editing = (field_q != F_NORMAL);
  assign sec     = sec_q;
  assign min     = min_q;
  assign hour    = hour_q;
  assign day     = day_q;
  assign month   = month_q;
  assign year_lo = year_lo_q;
  assign year_hi = year_hi_q;

endmodule
